// File: rtl/alu_branch_unit.sv
// ============================================================================
// alu_branch_unit
//
// Purpose:
//   Single-cycle-latency integer ALU with a multiply unit (hi/lo words) and a
//   companion branch-target unit. The ALU registers its result, zero flag,
//   overflow flag and done strobe on every rising edge while alu_en is high.
//   The branch unit registers the next PC on every rising edge while
//   branch_en is high, using the alu_zero value that was registered before
//   that edge.
//
// Ports:
//   clk           in   1   system clock, all state changes on rising edge
//   rst_n         in   1   asynchronous active-low reset
//   alu_en        in   1   ALU request; outputs recompute while high
//   alu_control   in   4   operation select (see op_e)
//   read_data1    in  32   register operand rs
//   shamt         in   5   shift amount field
//   select_shamt  in   1   1: srcA = zero-extended shamt, 0: srcA = read_data1
//   alu_srcB      in  32   second operand (rt or extended immediate)
//   alu_result    out 32   registered result (low word for multiplies)
//   hi            out 32   multiply high word
//   lo            out 32   multiply low word
//   overflow      out  1   signed overflow of ADD/SUB, 0 otherwise
//   alu_done      out  1   high the cycle after each enabled ALU edge
//   alu_zero      out  1   registered (alu_result == 0)
//   branch_en     in   1   branch unit request
//   branch        in   1   branch decision enable
//   imm           in  32   sign-extended word offset
//   pc            in  32   already-incremented word PC
//   pc_out        out 32   registered next PC
//   branch_done   out  1   high the cycle after each enabled branch edge
// ============================================================================
module alu_branch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_en,
    input  logic [3:0]  alu_control,
    input  logic [31:0] read_data1,
    input  logic [4:0]  shamt,
    input  logic        select_shamt,
    input  logic [31:0] alu_srcB,
    output logic [31:0] alu_result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        overflow,
    output logic        alu_done,
    output logic        alu_zero,
    input  logic        branch_en,
    input  logic        branch,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    output logic [31:0] pc_out,
    output logic        branch_done
);

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOR   = 4'd5,
        OP_SLT   = 4'd6,
        OP_SLTU  = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRL   = 4'd9,
        OP_SRA   = 4'd10,
        OP_MULT  = 4'd11,
        OP_MULTU = 4'd12,
        OP_LUI   = 4'd13,
        OP_SEQ   = 4'd14,
        OP_RSVD  = 4'd15
    } op_e;

    op_e         op;
    logic [31:0] src_a;
    logic [31:0] sum;
    logic [31:0] diff;
    logic        add_ovf;
    logic        sub_ovf;
    logic [4:0]  shift_amt;
    logic [31:0] sra_val;
    logic [63:0] prod_signed;
    logic [63:0] prod_unsigned;
    logic        slt_bit;

    logic [31:0] result_next;
    logic        overflow_next;
    logic        mul_update;
    logic [63:0] mul_next;

    assign op = op_e'(alu_control);

    // Operand A is either the register value or the zero-extended shamt field.
    assign src_a = select_shamt ? {27'b0, shamt} : read_data1;

    // Datapath pieces shared by several operations.
    assign sum       = src_a + alu_srcB;
    assign diff      = src_a - alu_srcB;
    assign shift_amt = src_a[4:0];
    assign sra_val   = $signed(alu_srcB) >>> shift_amt;

    // Overflow happens when operands of the same effective sign produce a
    // result of the opposite sign (B's sign is inverted for subtraction).
    assign add_ovf = (src_a[31] == alu_srcB[31]) && (sum[31]  != src_a[31]);
    assign sub_ovf = (src_a[31] != alu_srcB[31]) && (diff[31] != src_a[31]);

    // Signed A<B: if signs differ, the negative one is smaller; otherwise the
    // sign of the wrapped difference decides.
    assign slt_bit = (src_a[31] != alu_srcB[31]) ? src_a[31] : diff[31];

    // Full 64-bit products; signed version works on sign-extended operands.
    assign prod_signed   = {{32{src_a[31]}}, src_a} * {{32{alu_srcB[31]}}, alu_srcB};
    assign prod_unsigned = {32'b0, src_a} * {32'b0, alu_srcB};

    // Result select for every operation.
    always_comb begin
        result_next   = 32'b0;
        overflow_next = 1'b0;
        mul_update    = 1'b0;
        mul_next      = 64'b0;
        unique case (op)
            OP_ADD: begin
                result_next   = sum;
                overflow_next = add_ovf;
            end
            OP_SUB: begin
                result_next   = diff;
                overflow_next = sub_ovf;
            end
            OP_AND:  result_next = src_a & alu_srcB;
            OP_OR:   result_next = src_a | alu_srcB;
            OP_XOR:  result_next = src_a ^ alu_srcB;
            OP_NOR:  result_next = ~(src_a | alu_srcB);
            OP_SLT:  result_next = {31'b0, slt_bit};
            OP_SLTU: result_next = {31'b0, (src_a < alu_srcB)};
            OP_SLL:  result_next = alu_srcB << shift_amt;
            OP_SRL:  result_next = alu_srcB >> shift_amt;
            OP_SRA:  result_next = sra_val;
            OP_MULT: begin
                mul_update  = 1'b1;
                mul_next    = prod_signed;
                result_next = prod_signed[31:0];
            end
            OP_MULTU: begin
                mul_update  = 1'b1;
                mul_next    = prod_unsigned;
                result_next = prod_unsigned[31:0];
            end
            OP_LUI:  result_next = {alu_srcB[15:0], 16'b0};
            OP_SEQ:  result_next = {31'b0, (src_a == alu_srcB)};
            OP_RSVD: result_next = 32'b0;
            default: result_next = 32'b0;
        endcase
    end

    // ALU output registers. While alu_en is low everything except the done
    // strobe holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result <= 32'b0;
            overflow   <= 1'b0;
            alu_zero   <= 1'b0;
            alu_done   <= 1'b0;
        end else if (alu_en) begin
            alu_result <= result_next;
            overflow   <= overflow_next;
            alu_zero   <= (result_next == 32'b0);
            alu_done   <= 1'b1;
        end else begin
            alu_done   <= 1'b0;
        end
    end

    // hi/lo only change on an enabled multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= 32'b0;
            lo <= 32'b0;
        end else if (alu_en && mul_update) begin
            hi <= mul_next[63:32];
            lo <= mul_next[31:0];
        end
    end

    // Branch unit. alu_zero here is the registered flag from before this
    // edge, so a branch issued together with its compare sees the old flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out      <= 32'b0;
            branch_done <= 1'b0;
        end else if (branch_en) begin
            pc_out      <= (branch && alu_zero) ? (pc + imm) : pc;
            branch_done <= 1'b1;
        end else begin
            branch_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_branch_unit.sv
// ============================================================================
// tb_alu_branch_unit
//
// Self-checking bench for alu_branch_unit. A behavioural model computes each
// operation with 64-bit integer arithmetic and tracks the registered state of
// both units; directed scenarios are followed by a randomized run.
// ============================================================================
module tb_alu_branch_unit;

    localparam longint MAX_S32 = 2147483647;
    localparam longint MIN_S32 = -MAX_S32 - 1;

    logic        clk;
    logic        rst_n;
    logic        alu_en;
    logic [3:0]  alu_control;
    logic [31:0] read_data1;
    logic [4:0]  shamt;
    logic        select_shamt;
    logic [31:0] alu_srcB;
    logic [31:0] alu_result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        overflow;
    logic        alu_done;
    logic        alu_zero;
    logic        branch_en;
    logic        branch;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_out;
    logic        branch_done;

    int tests_run;
    int tests_failed;

    // Model state.
    logic [31:0] m_result, m_hi, m_lo, m_pc;
    logic        m_ovf, m_zero, m_done, m_bdone;

    alu_branch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_en       (alu_en),
        .alu_control  (alu_control),
        .read_data1   (read_data1),
        .shamt        (shamt),
        .select_shamt (select_shamt),
        .alu_srcB     (alu_srcB),
        .alu_result   (alu_result),
        .hi           (hi),
        .lo           (lo),
        .overflow     (overflow),
        .alu_done     (alu_done),
        .alu_zero     (alu_zero),
        .branch_en    (branch_en),
        .branch       (branch),
        .imm          (imm),
        .pc           (pc),
        .pc_out       (pc_out),
        .branch_done  (branch_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference operation: plain 64-bit arithmetic on the operand values.
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic ov, output logic mul,
                                    output logic [31:0] h, output logic [31:0] l);
        longint          sa, sb, s;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        r = 32'b0; ov = 1'b0; mul = 1'b0; h = 32'b0; l = 32'b0;
        case (op)
            4'd0: begin s = sa + sb; r = s[31:0]; ov = (s > MAX_S32) || (s < MIN_S32); end
            4'd1: begin s = sa - sb; r = s[31:0]; ov = (s > MAX_S32) || (s < MIN_S32); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~(a | b);
            4'd6: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd7: r = (ua < ub) ? 32'd1 : 32'd0;
            4'd8: r = b << a[4:0];
            4'd9: r = b >> a[4:0];
            4'd10: begin s = sb >>> a[4:0]; r = s[31:0]; end
            4'd11: begin s = sa * sb; {h, l} = s; mul = 1'b1; r = l; end
            4'd12: begin up = ua * ub; {h, l} = up; mul = 1'b1; r = l; end
            4'd13: r = {b[15:0], 16'h0000};
            4'd14: r = (a == b) ? 32'd1 : 32'd0;
            default: r = 32'b0;
        endcase
    endfunction

    task automatic modelReset();
        m_result = 32'b0; m_hi = 32'b0; m_lo = 32'b0; m_pc = 32'b0;
        m_ovf = 1'b0; m_zero = 1'b0; m_done = 1'b0; m_bdone = 1'b0;
    endtask

    // Advance the model by one rising edge using the current inputs.
    task automatic modelEdge();
        logic [31:0] a, r, h, l;
        logic        ov, mul;
        if (branch_en) begin
            m_pc    = (branch && m_zero) ? pc + imm : pc;
            m_bdone = 1'b1;
        end else begin
            m_bdone = 1'b0;
        end
        if (alu_en) begin
            a = select_shamt ? {27'b0, shamt} : read_data1;
            ref_alu(alu_control, a, alu_srcB, r, ov, mul, h, l);
            m_result = r;
            m_ovf    = ov;
            m_zero   = (r == 32'b0);
            m_done   = 1'b1;
            if (mul) begin
                m_hi = h;
                m_lo = l;
            end
        end else begin
            m_done = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, " result"},  alu_result,            m_result);
        checkOutput({tag, " hi"},      hi,                    m_hi);
        checkOutput({tag, " lo"},      lo,                    m_lo);
        checkOutput({tag, " ovf"},     {31'b0, overflow},     {31'b0, m_ovf});
        checkOutput({tag, " zero"},    {31'b0, alu_zero},     {31'b0, m_zero});
        checkOutput({tag, " done"},    {31'b0, alu_done},     {31'b0, m_done});
        checkOutput({tag, " pc_out"},  pc_out,                m_pc);
        checkOutput({tag, " bdone"},   {31'b0, branch_done},  {31'b0, m_bdone});
    endtask

    task automatic applyStimulus(input logic en, input logic [3:0] op, input logic sel,
                                 input logic [31:0] rd1, input logic [4:0] sh,
                                 input logic [31:0] b);
        alu_en       = en;
        alu_control  = op;
        select_shamt = sel;
        read_data1   = rd1;
        shamt        = sh;
        alu_srcB     = b;
    endtask

    task automatic applyBranch(input logic en, input logic br, input logic [31:0] p,
                               input logic [31:0] offs);
        branch_en = en;
        branch    = br;
        pc        = p;
        imm       = offs;
    endtask

    // One rising edge, model update, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 5'd0, 32'd0);
        applyBranch(1'b0, 1'b0, 32'd0, 32'd0);
        modelReset();
        #2;
        checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Signed overflow on ADD, then done drops when alu_en falls.
        applyStimulus(1'b1, 4'd0, 1'b0, 32'h7FFF_FFFF, 5'd0, 32'd1);
        tick();
        checkOutput("add_ovf result", alu_result, 32'h8000_0000);
        checkOutput("add_ovf flag", {31'b0, overflow}, 32'd1);
        checkAll("add_ovf");
        alu_en = 1'b0;
        tick();
        checkOutput("add_ovf done_drop", {31'b0, alu_done}, 32'd0);
        checkAll("add_ovf idle");

        // Shifts with srcA taken from shamt.
        applyStimulus(1'b1, 4'd10, 1'b1, $urandom, 5'd4, 32'h8000_0000);
        tick();
        checkOutput("sra shamt", alu_result, 32'hF800_0000);
        checkAll("sra");
        applyStimulus(1'b1, 4'd9, 1'b1, $urandom, 5'd4, 32'h8000_0000);
        tick();
        checkOutput("srl shamt", alu_result, 32'h0800_0000);
        checkAll("srl");

        // Signed multiply, then ADD must not disturb hi/lo.
        applyStimulus(1'b1, 4'd11, 1'b0, 32'hFFFF_FFFE, 5'd0, 32'd3);
        tick();
        checkOutput("mult hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult lo", lo, 32'hFFFF_FFFA);
        checkAll("mult");
        applyStimulus(1'b1, 4'd0, 1'b0, 32'd1, 5'd0, 32'd2);
        tick();
        checkOutput("add keeps hi", hi, 32'hFFFF_FFFF);
        checkOutput("add keeps lo", lo, 32'hFFFF_FFFA);
        checkAll("add after mult");

        // Taken branch after equal compare, not-taken after unequal compare.
        applyStimulus(1'b1, 4'd1, 1'b0, 32'd5, 5'd0, 32'd5);
        tick();
        checkOutput("beq zero", {31'b0, alu_zero}, 32'd1);
        alu_en = 1'b0;
        applyBranch(1'b1, 1'b1, 32'd10, 32'hFFFF_FFFD);
        tick();
        checkOutput("beq taken pc", pc_out, 32'd7);
        checkOutput("beq taken done", {31'b0, branch_done}, 32'd1);
        checkAll("beq taken");
        branch_en = 1'b0;
        applyStimulus(1'b1, 4'd1, 1'b0, 32'd5, 5'd0, 32'd4);
        tick();
        checkAll("sub unequal");
        alu_en = 1'b0;
        applyBranch(1'b1, 1'b1, 32'd10, 32'hFFFF_FFFD);
        tick();
        checkOutput("beq not taken pc", pc_out, 32'd10);
        checkAll("beq not taken");
        branch_en = 1'b0;
        tick();
        checkOutput("bdone drop", {31'b0, branch_done}, 32'd0);
        checkOutput("pc hold", pc_out, 32'd10);

        // Signed vs unsigned compare.
        applyStimulus(1'b1, 4'd6, 1'b0, 32'hFFFF_FFFF, 5'd0, 32'd1);
        tick();
        checkOutput("slt", alu_result, 32'd1);
        checkAll("slt");
        applyStimulus(1'b1, 4'd7, 1'b0, 32'hFFFF_FFFF, 5'd0, 32'd1);
        tick();
        checkOutput("sltu", alu_result, 32'd0);
        checkOutput("sltu zero", {31'b0, alu_zero}, 32'd1);
        checkAll("sltu");

        // Compare and branch on the same edge: branch sees the old flag (1).
        applyStimulus(1'b1, 4'd14, 1'b0, 32'd3, 5'd0, 32'd3);
        applyBranch(1'b1, 1'b1, 32'd100, 32'd20);
        tick();
        checkOutput("same edge pc", pc_out, 32'd120);
        checkAll("same edge");

        // Asynchronous reset between edges while done is high.
        applyStimulus(1'b1, 4'd11, 1'b0, 32'h1234_5678, 5'd0, 32'h9ABC_DEF0);
        applyBranch(1'b1, 1'b0, 32'd44, 32'd4);
        tick();
        checkAll("pre reset");
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("async reset");
        checkOutput("async reset result", alu_result, 32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b0, 32'd7, 5'd0, 32'd7);
        applyBranch(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        checkAll("post reset idle");
        tick();
        checkAll("post reset idle2");

        // Randomized run against the model.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(3) != 0), 4'($urandom_range(15)),
                          1'($urandom_range(1)), $urandom, 5'($urandom_range(31)),
                          ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom);
            if ($urandom_range(3) == 0)
                read_data1 = alu_srcB;
            applyBranch(($urandom_range(1) == 1), ($urandom_range(1) == 1), $urandom, $urandom);
            tick();
            checkAll("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_branch_unit.md
ALU_BRANCH_UNIT -- requirements
Module: alu_branch_unit

Interface
REQ-001 Parameters: none.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 alu_en  in  1  ALU enable/request.
REQ-006 alu_control  in  4  operation select (REQ-013).
REQ-007 read_data1  in  32  register operand (rs).
REQ-008 shamt  in  5  shift amount field.
REQ-009 select_shamt  in  1  1: srcA = {27'b0, shamt}; 0: srcA = read_data1 (combinational mux).
REQ-010 alu_srcB  in  32  second operand (rt or extended immediate).
REQ-011 alu_result/hi/lo  out  32 each  registered result, multiply high word, multiply low word; overflow  out  1; alu_done  out  1; alu_zero  out  1.
REQ-012 branch_en  in  1; branch  in  1  branch decision enable; imm  in  32  sign-extended word offset; pc  in  32  already-incremented word PC; pc_out  out  32; branch_done  out  1.

Function
REQ-013 alu_control encoding, A = srcA, B = alu_srcB, all 32-bit:
- 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOR.
- 6 SLT: signed A<B gives 1, else 0; 7 SLTU: unsigned compare.
- 8 SLL B<<A[4:0]; 9 SRL logical; 10 SRA arithmetic.
- 11 MULT signed {hi,lo}=A*B; 12 MULTU unsigned.
- 13 LUI B<<16; 14 SEQ: (A==B)?1:0; 15 reserved, result 0.
REQ-014 On a rising edge with alu_en=1: alu_result, alu_zero (alu_result==0 of the new value), overflow and alu_done=1 register together; 1-cycle latency.
REQ-015 alu_done SHALL stay 1 and the outputs SHALL recompute each cycle while alu_en=1; first edge with alu_en=0 clears alu_done; result, zero, hi and lo hold.
REQ-016 overflow = signed two's-complement overflow for ADD/SUB; 0 for all other ops.
REQ-017 hi/lo update only on MULT/MULTU with alu_result = low word; other ops leave hi/lo unchanged.
REQ-018 All arithmetic wraps modulo 2^32; shift amount uses only A[4:0].
REQ-019 beq: SUB, alu_zero=1 when equal; bne: SEQ, alu_zero=1 when unequal.
REQ-020 On a rising edge with branch_en=1: pc_out = (branch & alu_zero) ? pc+imm : pc (mod 2^32, word units), and branch_done=1.
REQ-021 branch_done stays 1 while branch_en=1; first edge with branch_en=0 clears it; pc_out holds.
REQ-022 Branch uses the registered alu_zero value present at that edge.
REQ-023 alu_en and branch_en both high on one edge: each unit acts independently; branch sees the pre-edge alu_zero.

Reset
REQ-024 rst_n=0 immediately forces alu_result, hi, lo, pc_out = 0 and overflow, alu_zero, alu_done, branch_done = 0, regardless of clk.
REQ-025 Reset mid-operation aborts it. After rst_n rises, the first enabled edge behaves as in REQ-014/REQ-020.

Verification
REQ-026 ADD 0x7FFFFFFF + 1, alu_en 1 cycle -> alu_result 0x80000000, overflow 1, alu_done 1 after 1 edge, 0 one edge after alu_en drops.
REQ-027 select_shamt=1, shamt=4, B=0x80000000: SRA -> 0xF8000000; SRL -> 0x08000000; read_data1 ignored.
REQ-028 MULT A=-2, B=3 -> hi 0xFFFFFFFF, lo 0xFFFFFFFA; a following ADD leaves hi/lo unchanged.
REQ-029 SUB 5-5 (alu_zero=1), then branch=1, pc=10, imm=0xFFFFFFFD -> pc_out 7, branch_done 1; SUB 5-4 repeat -> pc_out 10.
REQ-030 SLT A=-1, B=1 -> 1; SLTU same operands -> 0, alu_zero 1.
REQ-031 rst_n pulsed low between clock edges while alu_done=1 -> all outputs 0 immediately; outputs remain 0 until next enabled edge.
